// File: rtl/pkt_rr_arbiter.sv
// Round-robin packet arbiter: per-queue FWFT FIFOs merged into one output stream, switching
// queues only on packet boundaries. Keeps per-queue packet counts and sticky overflow flags.
module pkt_rr_arbiter #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned CTRL_WIDTH      = 8,
  parameter int unsigned NUM_QUEUES      = 4,
  parameter int unsigned FIFO_DEPTH_BITS = 5
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data_i,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl_i,
  input  logic [NUM_QUEUES-1:0]            in_wr_i,
  output logic [NUM_QUEUES-1:0]            in_rdy_o,
  output logic [DATA_WIDTH-1:0]            out_data_o,
  output logic [CTRL_WIDTH-1:0]            out_ctrl_o,
  output logic                             out_wr_o,
  input  logic                             out_rdy_i,
  output logic [NUM_QUEUES-1:0]            grant_o,
  output logic [NUM_QUEUES*32-1:0]         pkt_count_o,
  output logic [NUM_QUEUES-1:0]            overflow_o
);

  localparam int unsigned Depth = 2 ** FIFO_DEPTH_BITS;
  localparam int unsigned QW    = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
  localparam int unsigned EW    = CTRL_WIDTH + DATA_WIDTH;
  localparam int unsigned CntW  = FIFO_DEPTH_BITS + 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StXfer = 1'b1;

  logic [EW-1:0]              mem_q     [NUM_QUEUES][Depth];
  logic [FIFO_DEPTH_BITS-1:0] wptr_q    [NUM_QUEUES];
  logic [FIFO_DEPTH_BITS-1:0] rptr_q    [NUM_QUEUES];
  logic [CntW-1:0]            cnt_q     [NUM_QUEUES];
  logic [31:0]                pkt_cnt_q [NUM_QUEUES];
  logic [NUM_QUEUES-1:0]      ovf_q;

  logic [0:0]            state_q, state_d;
  logic [NUM_QUEUES-1:0] grant_q, grant_d;
  logic [QW-1:0]         gidx_q, gidx_d;
  logic [QW-1:0]         rr_q, rr_d;

  logic                  out_wr_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CTRL_WIDTH-1:0] out_ctrl_q;

  logic [NUM_QUEUES-1:0] empty, full, push, pop;
  logic [EW-1:0]         head;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic                  head_eop;
  logic                  pop_any;
  logic                  found;
  logic [QW-1:0]         sel;
  logic [QW-1:0]         idx;

  // A full FIFO still accepts a write in the same cycle it is popped.
  always_comb begin
    empty    = '0;
    full     = '0;
    push     = '0;
    pop      = '0;
    in_rdy_o = '0;
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      empty[i]    = (cnt_q[i] == '0);
      full[i]     = (cnt_q[i] == CntW'(Depth));
      in_rdy_o[i] = (cnt_q[i] <= CntW'(Depth - 3));
      pop[i]      = (state_q == StXfer) && grant_q[i] && !empty[i] && out_rdy_i;
      push[i]     = in_wr_i[i] && (!full[i] || pop[i]);
    end
  end

  always_comb begin
    head      = mem_q[gidx_q][rptr_q[gidx_q]];
    head_ctrl = head[EW-1 -: CTRL_WIDTH];
    head_eop  = (head_ctrl != '0) && (head_ctrl != '1);
    pop_any   = |pop;
  end

  // First non-empty queue at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_QUEUES; k++) begin
      idx = QW'((32'(rr_q) + k) % NUM_QUEUES);
      if (!found && !empty[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StXfer;
          gidx_d  = sel;
          grant_d = NUM_QUEUES'(1) << sel;
        end
      end
      StXfer: begin
        if (pop_any && head_eop) begin
          state_d = StIdle;
          grant_d = '0;
          rr_d    = (gidx_q == QW'(NUM_QUEUES - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= {in_ctrl_i[i*CTRL_WIDTH +: CTRL_WIDTH],
                                in_data_i[i*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
        wptr_q[i]    <= '0;
        rptr_q[i]    <= '0;
        cnt_q[i]     <= '0;
        pkt_cnt_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
        if (pop[i])  rptr_q[i] <= rptr_q[i] + 1'b1;
        if (push[i] && !pop[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (pop[i] && !push[i]) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
        if (in_wr_i[i] && !push[i]) ovf_q[i] <= 1'b1;
        if (pop[i] && head_eop) pkt_cnt_q[i] <= pkt_cnt_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_q       <= '0;
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_q     <= rr_d;
      out_wr_q <= pop_any;
      if (pop_any) begin
        out_data_q <= head[DATA_WIDTH-1:0];
        out_ctrl_q <= head_ctrl;
      end
    end
  end

  always_comb begin
    pkt_count_o = '0;
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      pkt_count_o[i*32 +: 32] = pkt_cnt_q[i];
    end
  end

  assign out_wr_o   = out_wr_q;
  assign out_data_o = out_data_q;
  assign out_ctrl_o = out_ctrl_q;
  assign grant_o    = grant_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Self-checking bench for pkt_rr_arbiter: directed framing/latency/overflow/reset scenarios and
// randomized multi-queue bursts checked against a round-robin packet-order model.
module tb_pkt_rr_arbiter;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int NQ = 4;
  localparam int DB = 5;
  localparam int D  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NQ*DW-1:0]  in_data;
  logic [NQ*CW-1:0]  in_ctrl;
  logic [NQ-1:0]     in_wr;
  logic [NQ-1:0]     in_rdy;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_ctrl;
  logic              out_wr;
  logic              out_rdy;
  logic [NQ-1:0]     grant;
  logic [NQ*32-1:0]  pkt_count;
  logic [NQ-1:0]     overflow;

  pkt_rr_arbiter #(
    .DATA_WIDTH     (DW),
    .CTRL_WIDTH     (CW),
    .NUM_QUEUES     (NQ),
    .FIFO_DEPTH_BITS(DB)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .in_data_i  (in_data),
    .in_ctrl_i  (in_ctrl),
    .in_wr_i    (in_wr),
    .in_rdy_o   (in_rdy),
    .out_data_o (out_data),
    .out_ctrl_o (out_ctrl),
    .out_wr_o   (out_wr),
    .out_rdy_i  (out_rdy),
    .grant_o    (grant),
    .pkt_count_o(pkt_count),
    .overflow_o (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt[NQ];
  int exp_rr;
  logic [71:0] mon_q[$];
  logic [71:0] exp_q[$];

  always @(negedge clk) begin
    if (out_wr === 1'b1) mon_q.push_back({out_ctrl, out_data});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int q, input logic [7:0] c, input logic [63:0] d);
    in_wr[q]            = 1'b1;
    in_ctrl[q*CW +: CW] = c;
    in_data[q*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    in_wr   = '0;
    reset   = 1'b1;
    step();
    step();
    reset   = 1'b0;
    exp_rr  = 0;
    for (int q = 0; q < NQ; q++) exp_cnt[q] = 0;
  endtask

  task automatic test_reset();
    in_data = '0;
    in_ctrl = '0;
    out_rdy = 1'b1;
    apply_reset();
    step();
    n_checks += 7;
    if (out_wr !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_wr got=%b exp=0", out_wr);
    end
    if (grant !== '0) begin
      n_fail++; $display("FAIL reset_grant got=%b exp=0000", grant);
    end
    if (out_data !== '0) begin
      n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data);
    end
    if (out_ctrl !== '0) begin
      n_fail++; $display("FAIL reset_out_ctrl got=%h exp=0", out_ctrl);
    end
    if (pkt_count !== '0) begin
      n_fail++; $display("FAIL reset_pkt_count got=%h exp=0", pkt_count);
    end
    if (overflow !== '0) begin
      n_fail++; $display("FAIL reset_overflow got=%b exp=0000", overflow);
    end
    if (in_rdy !== 4'hf) begin
      n_fail++; $display("FAIL reset_in_rdy got=%b exp=1111", in_rdy);
    end
  endtask

  // 4-word packet on q0: first out_wr two cycles after the FIFO turns non-empty.
  task automatic test_single_packet();
    logic [7:0]  c4 [4];
    logic [63:0] d4 [4];
    logic        e_wr;
    logic [3:0]  e_gr;
    c4 = '{8'hff, 8'h00, 8'h00, 8'h08};
    for (int w = 0; w < 4; w++) d4[w] = {$urandom(), $urandom()};
    for (int c = 0; c < 9; c++) begin
      if (c < 4) drive(0, c4[c], d4[c]);
      else in_wr = '0;
      step();
      e_wr = (c >= 2 && c <= 5);
      e_gr = (c >= 1 && c <= 4) ? 4'b0001 : 4'b0000;
      n_checks += 2;
      if (out_wr !== e_wr) begin
        n_fail++; $display("FAIL single_out_wr cyc=%0d got=%b exp=%b", c, out_wr, e_wr);
      end
      if (grant !== e_gr) begin
        n_fail++; $display("FAIL single_grant cyc=%0d got=%b exp=%b", c, grant, e_gr);
      end
      if (e_wr) begin
        n_checks++;
        if ({out_ctrl, out_data} !== {c4[c-2], d4[c-2]}) begin
          n_fail++;
          $display("FAIL single_word cyc=%0d got=%h exp=%h", c, {out_ctrl, out_data},
                   {c4[c-2], d4[c-2]});
        end
      end
    end
    exp_cnt[0]++;
    exp_rr = 1;
    n_checks++;
    if (pkt_count[31:0] !== 32'(exp_cnt[0])) begin
      n_fail++; $display("FAIL single_pkt_count got=%0d exp=%0d", pkt_count[31:0], exp_cnt[0]);
    end
  endtask

  // Packets written to several queues in lockstep; expected stream is the round-robin
  // concatenation of whole packets starting at the model pointer.
  task automatic test_round_robin();
    logic [71:0] wq   [NQ][$];
    int          plen [NQ][$];
    int          rdx  [NQ];
    int          pk   [NQ];
    int          mask, npk, len, left, ptr, q, maxw, guard;
    logic [7:0]  c;
    apply_reset();
    for (int it = 0; it < 12; it++) begin
      mon_q.delete();
      exp_q.delete();
      mask = (it == 0) ? 4'hf : (it == 1) ? 4'h2 : (it == 2) ? 4'ha : $urandom_range(1, 15);
      left = 0;
      maxw = 0;
      for (int qq = 0; qq < NQ; qq++) begin
        wq[qq].delete();
        plen[qq].delete();
        rdx[qq] = 0;
        pk[qq]  = 0;
        if (mask[qq]) begin
          npk = (it < 2) ? 1 : (it == 2) ? 3 : $urandom_range(1, 3);
          for (int p = 0; p < npk; p++) begin
            len = (it < 3) ? 3 : $urandom_range(1, 5);
            plen[qq].push_back(len);
            left++;
            for (int w = 0; w < len; w++) begin
              if (w == len - 1) c = 8'($urandom_range(1, 254));
              else c = $urandom_range(0, 1) ? 8'hff : 8'h00;
              wq[qq].push_back({c, 8'(qq), 8'(p), 8'(w), 32'($urandom()), 8'(it)});
            end
          end
          if (wq[qq].size() > maxw) maxw = wq[qq].size();
        end
      end
      ptr = exp_rr;
      while (left > 0) begin
        for (int k = 0; k < NQ; k++) begin
          q = (ptr + k) % NQ;
          if (pk[q] < plen[q].size()) begin
            for (int w = 0; w < plen[q][pk[q]]; w++) exp_q.push_back(wq[q][rdx[q] + w]);
            rdx[q] += plen[q][pk[q]];
            pk[q]++;
            exp_cnt[q]++;
            ptr = (q + 1) % NQ;
            left--;
            break;
          end
        end
      end
      exp_rr = ptr;
      for (int t = 0; t < maxw; t++) begin
        for (int qq = 0; qq < NQ; qq++) begin
          if (t < wq[qq].size()) drive(qq, wq[qq][t][71:64], wq[qq][t][63:0]);
          else in_wr[qq] = 1'b0;
        end
        out_rdy = (it < 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
        step();
      end
      in_wr = '0;
      guard = 0;
      while (mon_q.size() < exp_q.size() && guard < 2000) begin
        out_rdy = (it < 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
        step();
        guard++;
      end
      out_rdy = 1'b1;
      repeat (4) step();
      n_checks++;
      if (mon_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rr_len it=%0d got=%0d exp=%0d", it, mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
        n_checks++;
        if (mon_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rr_word it=%0d i=%0d got=%h exp=%h", it, i, mon_q[i], exp_q[i]);
        end
      end
      n_checks += 2;
      if (grant !== '0) begin
        n_fail++; $display("FAIL rr_grant_idle it=%0d got=%b exp=0000", it, grant);
      end
      if (overflow !== '0) begin
        n_fail++; $display("FAIL rr_overflow it=%0d got=%b exp=0000", it, overflow);
      end
      for (int qq = 0; qq < NQ; qq++) begin
        n_checks++;
        if (pkt_count[qq*32 +: 32] !== 32'(exp_cnt[qq])) begin
          n_fail++;
          $display("FAIL rr_pkt_count it=%0d q=%0d got=%0d exp=%0d", it, qq,
                   pkt_count[qq*32 +: 32], exp_cnt[qq]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int guard, nwr;
    mon_q.delete();
    exp_q.delete();
    out_rdy = 1'b0;
    for (int w = 0; w < 8; w++) begin
      exp_q.push_back({(w == 7) ? 8'h21 : ((w == 0) ? 8'hff : 8'h00), {$urandom(), $urandom()}});
      drive(2, exp_q[w][71:64], exp_q[w][63:0]);
      step();
    end
    in_wr   = '0;
    out_rdy = 1'b1;
    guard   = 0;
    while (mon_q.size() < 3 && guard < 100) begin
      step();
      guard++;
    end
    out_rdy = 1'b0;
    nwr = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (out_wr === 1'b1) nwr++;
      n_checks++;
      if (grant !== 4'b0100) begin
        n_fail++; $display("FAIL bp_grant cyc=%0d got=%b exp=0100", c, grant);
      end
    end
    n_checks++;
    if (nwr > 1) begin
      n_fail++; $display("FAIL bp_trailing_wr got=%0d exp<=1", nwr);
    end
    out_rdy = 1'b1;
    guard = 0;
    while (mon_q.size() < exp_q.size() && guard < 100) begin
      step();
      guard++;
    end
    repeat (3) step();
    exp_cnt[2]++;
    exp_rr = 3;
    n_checks++;
    if (mon_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bp_len got=%0d exp=%0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_word i=%0d got=%h exp=%h", i, mon_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (pkt_count[2*32 +: 32] !== 32'(exp_cnt[2])) begin
      n_fail++; $display("FAIL bp_pkt_count got=%0d exp=%0d", pkt_count[2*32 +: 32], exp_cnt[2]);
    end
  endtask

  // 34 writes into q2 with the output stalled: entries 33 and 34 must be dropped.
  task automatic test_overflow();
    logic [71:0] wd;
    logic        e_rdy, e_ovf;
    int          guard, stored;
    mon_q.delete();
    exp_q.delete();
    out_rdy = 1'b0;
    for (int k = 1; k <= D + 2; k++) begin
      wd = {(k >= D) ? 8'h08 : 8'h00, 32'(k), $urandom()};
      if (k <= D) exp_q.push_back(wd);
      drive(2, wd[71:64], wd[63:0]);
      step();
      stored = (k < D) ? k : D;
      e_rdy  = (stored <= D - 3);
      e_ovf  = (k > D);
      n_checks += 2;
      if (in_rdy[2] !== e_rdy) begin
        n_fail++; $display("FAIL ovf_in_rdy k=%0d got=%b exp=%b", k, in_rdy[2], e_rdy);
      end
      if (overflow[2] !== e_ovf) begin
        n_fail++; $display("FAIL ovf_flag k=%0d got=%b exp=%b", k, overflow[2], e_ovf);
      end
    end
    in_wr   = '0;
    out_rdy = 1'b1;
    guard   = 0;
    while (mon_q.size() < exp_q.size() && guard < 200) begin
      step();
      guard++;
    end
    repeat (6) step();
    exp_cnt[2]++;
    exp_rr = 3;
    n_checks += 3;
    if (mon_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL ovf_len got=%0d exp=%0d", mon_q.size(), exp_q.size());
    end
    if (overflow !== 4'b0100) begin
      n_fail++; $display("FAIL ovf_sticky got=%b exp=0100", overflow);
    end
    if (pkt_count[2*32 +: 32] !== 32'(exp_cnt[2])) begin
      n_fail++; $display("FAIL ovf_pkt_count got=%0d exp=%0d", pkt_count[2*32 +: 32], exp_cnt[2]);
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL ovf_word i=%0d got=%h exp=%h", i, mon_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    int guard;
    out_rdy = 1'b1;
    for (int w = 0; w < 8; w++) begin
      drive(1, (w == 7) ? 8'h04 : 8'h00, {$urandom(), $urandom()});
      step();
    end
    in_wr = '0;
    guard = 0;
    while (out_wr !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    n_checks++;
    if (out_wr !== 1'b1 || grant !== 4'b0010) begin
      n_fail++; $display("FAIL arst_pre_xfer got=%b/%b exp=1/0010", out_wr, grant);
    end
    #3;
    reset = 1'b1;
    #1;
    n_checks += 4;
    if (out_wr !== 1'b0) begin
      n_fail++; $display("FAIL arst_out_wr got=%b exp=0", out_wr);
    end
    if (grant !== '0) begin
      n_fail++; $display("FAIL arst_grant got=%b exp=0000", grant);
    end
    if (pkt_count !== '0) begin
      n_fail++; $display("FAIL arst_pkt_count got=%h exp=0", pkt_count);
    end
    if (overflow !== '0) begin
      n_fail++; $display("FAIL arst_overflow got=%b exp=0000", overflow);
    end
    step();
    reset  = 1'b0;
    exp_rr = 0;
    for (int q = 0; q < NQ; q++) exp_cnt[q] = 0;
    step();
    mon_q.delete();
    exp_q.delete();
    for (int w = 0; w < 3; w++) begin
      exp_q.push_back({(w == 0) ? 8'hff : ((w == 1) ? 8'h00 : 8'h05), {$urandom(), $urandom()}});
      drive(0, exp_q[w][71:64], exp_q[w][63:0]);
      step();
    end
    in_wr = '0;
    guard = 0;
    while (mon_q.size() < exp_q.size() && guard < 100) begin
      step();
      guard++;
    end
    repeat (3) step();
    exp_cnt[0]++;
    n_checks += 2;
    if (mon_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL arst_len got=%0d exp=%0d", mon_q.size(), exp_q.size());
    end
    if (pkt_count !== {96'd0, 32'(exp_cnt[0])}) begin
      n_fail++; $display("FAIL arst_pkt_count_after got=%h exp=%0d", pkt_count, exp_cnt[0]);
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL arst_word i=%0d got=%h exp=%h", i, mon_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    in_wr   = '0;
    in_data = '0;
    in_ctrl = '0;
    out_rdy = 1'b1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_rr_arbiter.md
Name: pkt_rr_arbiter

Overview:
- Round-robin packet arbiter at the head of the user datapath.
- Buffers NUM_QUEUES independent input streams in per-queue FIFOs.
- Merges them into one output stream, one whole packet at a time, so downstream modules such as estimation and filtering stages see unbroken packets.
- Keeps a forwarded-packet count per queue and sticky overflow flags for software status.

Parameters:
DATA_WIDTH, 64, data word width
CTRL_WIDTH, 8, control word width
NUM_QUEUES, 4, number of input queues (2..8)
FIFO_DEPTH_BITS, 5, log2 of per-queue FIFO depth (depth D = 2**FIFO_DEPTH_BITS)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
in_data  input  NUM_QUEUES*DATA_WIDTH  packed input data, queue i at [i*DATA_WIDTH +: DATA_WIDTH]
in_ctrl  input  NUM_QUEUES*CTRL_WIDTH  packed input ctrl, same packing
in_wr  input  NUM_QUEUES  per-queue write strobe
in_rdy  output  NUM_QUEUES  per-queue ready (not nearly full)
out_data  output  DATA_WIDTH  merged output data
out_ctrl  output  CTRL_WIDTH  merged output ctrl
out_wr  output  1  output word valid
out_rdy  input  1  downstream can take at least one more word
grant  output  NUM_QUEUES  one-hot queue currently being forwarded; 0 when idle
pkt_count  output  NUM_QUEUES*32  per-queue forwarded-packet counters
overflow  output  NUM_QUEUES  sticky flag: a write arrived while the FIFO was full

Behaviour:
- Reset (asynchronous, active-high; clears immediately, without waiting for clk):
  - FIFOs emptied; state IDLE; rr_ptr = 0.
  - out_wr = 0; out_data = 0; out_ctrl = 0; grant = 0.
  - pkt_count = 0; overflow = 0.
  - in_rdy = all ones once reset deasserts.
- FIFO per queue:
  - First-word-fall-through, D entries of {ctrl, data}.
  - in_rdy[i] = (count[i] <= D-3).
  - A write with count == D discards the word and sets overflow[i]; the flag clears only on reset.
  - A simultaneous read and write at count == D is accepted.
- Packet framing:
  - A packet is every word up to and including the EOP word.
  - EOP word: ctrl != 0 and ctrl != 8'hff.
  - Module-header words (ctrl == 8'hff) and payload words (ctrl == 0) are forwarded unchanged.
- FSM states IDLE and XFER:
  - IDLE: search queues rr_ptr, rr_ptr+1, ... (mod NUM_QUEUES) for the first non-empty FIFO.
  - If one is found, grant becomes that one-hot queue on the next edge and the state moves to XFER. No word is read in IDLE.
  - XFER: each cycle with granted FIFO non-empty and out_rdy = 1, pop one word.
  - The popped word appears on out_data/out_ctrl with out_wr = 1 on the next cycle (registered output, latency 1). Otherwise out_wr = 0 that next cycle.
  - When the popped word is EOP:
    - pkt_count[grant] increments; the counter wraps at 2**32.
    - rr_ptr <= granted index + 1 mod NUM_QUEUES.
    - grant <= 0 and state <= IDLE.
- Minimum inter-packet gap on out_wr: 1 cycle (the IDLE cycle).
- Granted FIFO runs empty mid-packet: stay in XFER with no pop and out_wr = 0. Other queues are never interleaved into the packet.
- out_rdy low: no pop. Words already registered still present normally; downstream nearly-full semantics absorb the one extra word.
- Writes into the granted queue during XFER are accepted normally.
- A queue with traffic is served within NUM_QUEUES-1 packets of any other queue (no starvation).
- A reset mid-packet truncates the packet output; no recovery is attempted.

Test Plan:
- One 4-word packet (ctrl ff, 00, 00, 08) on queue 0, out_rdy = 1 -> 4 consecutive out_wr words, identical ctrl/data, first word 2 cycles after FIFO non-empty; pkt_count[0] = 1; grant = 0001 during the transfer.
- One 3-word packet preloaded on each of queues 0..3 -> output order q0, q1, q2, q3, each packet contiguous, 1-cycle gaps; every pkt_count = 1; rr_ptr returns to 0.
- Queue 1 and queue 3 continuously loaded, rr_ptr = 2 -> order q3, q1, q3, q1 ...; no packet interleaving.
- out_rdy held low for 5 cycles mid-packet -> no pops and at most one trailing out_wr after out_rdy falls; packet resumes intact with no lost or duplicated word.
- 34 writes to queue 2 with no reads and D = 32 -> in_rdy[2] falls at count 30; words 33-34 dropped; overflow[2] = 1 and stays 1.
- Reset asserted asynchronously mid-XFER -> out_wr, grant and pkt_count clear before the next edge; a fresh packet afterwards is forwarded from queue 0 correctly.
